// File: rtl/i2s_frame_read_scheduler_pkg.sv
// Shared constants and FSM state type for the I2S frame read scheduler.
package i2s_frame_read_scheduler_pkg;

  localparam int unsigned WORDS_PER_FRAME = 8;
  localparam int unsigned BITS_PER_WORD   = 32;
  localparam int unsigned FRAME_BITS      = WORDS_PER_FRAME * BITS_PER_WORD;
  localparam int unsigned WORD_IDX_W      = $clog2(WORDS_PER_FRAME);
  localparam int unsigned BIT_IDX_W       = $clog2(BITS_PER_WORD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/i2s_bit_packer.sv
// Serial-in word packer: issues 32 RAM bit reads and shifts the returned
// bits in MSB first, one cycle behind the read strobe.
module i2s_bit_packer
  import i2s_frame_read_scheduler_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     run_i,
  input  logic                     bit_i,
  output logic                     rd_en_o,
  output logic [BIT_IDX_W-1:0]     bit_idx_o,
  output logic [BITS_PER_WORD-1:0] word_o,
  output logic                     done_o
);

  // issue_cnt counts issued reads; its MSB marks all 32 addresses sent
  logic [BIT_IDX_W:0] issue_cnt;
  logic               rd_en_q;

  // Read strobe while addresses remain; done when the last returned bit lands
  always_comb begin
    rd_en_o   = run_i && !issue_cnt[BIT_IDX_W];
    bit_idx_o = issue_cnt[BIT_IDX_W-1:0];
    done_o    = rd_en_q && issue_cnt[BIT_IDX_W];
  end

  // Address counter plus shift register fed by the delayed read strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issue_cnt <= '0;
      rd_en_q   <= 1'b0;
      word_o    <= '0;
    end else begin
      rd_en_q <= rd_en_o;
      if (!run_i)
        issue_cnt <= '0;
      else if (rd_en_o)
        issue_cnt <= issue_cnt + (BIT_IDX_W+1)'(1);
      if (rd_en_q)
        word_o <= {word_o[BITS_PER_WORD-2:0], bit_i};
    end
  end

endmodule

// File: rtl/i2s_frame_read_scheduler.sv
// Reads completed 256-bit frames out of the capture ring and streams them
// as eight 32-bit words, tracking availability and writer overrun.
module i2s_frame_read_scheduler
  import i2s_frame_read_scheduler_pkg::*;
#(
  parameter int unsigned CIRC_BUF_BITS = 3
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        enable_i,
  input  logic [CIRC_BUF_BITS-1:0]                    last_good_frame_idx_i,
  output logic [CIRC_BUF_BITS+$clog2(FRAME_BITS)-1:0] ram_read_addr_o,
  output logic                                        ram_read_en_o,
  input  logic                                        ram_read_data_i,
  output logic [BITS_PER_WORD-1:0]                    word_data_o,
  output logic                                        word_valid_o,
  input  logic                                        word_ready_i,
  output logic                                        word_last_o,
  output logic                                        word_err_o,
  output logic [CIRC_BUF_BITS-1:0]                    frame_idx_o,
  output logic                                        overrun_o
);

  localparam int unsigned            AVAIL_W   = CIRC_BUF_BITS + 1;
  localparam logic [AVAIL_W-1:0]     AVAIL_MAX = AVAIL_W'((1 << CIRC_BUF_BITS) - 1);
  localparam logic [WORD_IDX_W-1:0]  LAST_WORD = WORD_IDX_W'(WORDS_PER_FRAME - 1);

  state_t                   state, state_d;
  logic [CIRC_BUF_BITS-1:0] last_good_q;
  logic                     armed, armed_d;
  logic [AVAIL_W-1:0]       avail, avail_d;
  logic [CIRC_BUF_BITS-1:0] rd_frame, rd_frame_d;
  logic                     err_r, err_d;
  logic                     en_drop_r, en_drop_d;
  logic [WORD_IDX_W-1:0]    word_idx;
  logic                     ev_en, handshake, frame_done, overrun_d;
  logic                     pk_rd_en, pk_done;
  logic [BIT_IDX_W-1:0]     pk_bit_idx;
  logic [BITS_PER_WORD-1:0] pk_word;

  i2s_bit_packer u_packer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .run_i     (state == READ),
    .bit_i     (ram_read_data_i),
    .rd_en_o   (pk_rd_en),
    .bit_idx_o (pk_bit_idx),
    .word_o    (pk_word),
    .done_o    (pk_done)
  );

  // Frame accounting: event detection, availability, read pointer, overrun.
  // Completion takes priority; an overrun-marked frame resyncs to the newest
  // index instead of advancing, and an enable drop seen during the frame
  // disarms at completion.
  always_comb begin
    ev_en      = (last_good_frame_idx_i != last_good_q) && enable_i;
    handshake  = (state == HOLD) && word_ready_i;
    frame_done = handshake && (word_idx == LAST_WORD);
    armed_d    = armed;
    avail_d    = avail;
    rd_frame_d = rd_frame;
    err_d      = err_r;
    en_drop_d  = en_drop_r;
    overrun_d  = 1'b0;
    if ((state != IDLE) && !enable_i)
      en_drop_d = 1'b1;
    if (frame_done) begin
      en_drop_d = 1'b0;
      err_d     = 1'b0;
      if (en_drop_r || !enable_i) begin
        armed_d = 1'b0;
        avail_d = '0;
      end else if (err_r) begin
        rd_frame_d = last_good_frame_idx_i;
        avail_d    = AVAIL_W'(1);
      end else begin
        rd_frame_d = rd_frame + CIRC_BUF_BITS'(1);
        if (!ev_en)
          avail_d = avail - AVAIL_W'(1);
      end
    end else if ((state == IDLE) && !enable_i) begin
      armed_d = 1'b0;
      avail_d = '0;
    end else if (ev_en) begin
      if (!armed) begin
        armed_d    = 1'b1;
        avail_d    = AVAIL_W'(1);
        rd_frame_d = last_good_frame_idx_i;
      end else if (err_r) begin
        avail_d = avail;
      end else if (avail == AVAIL_MAX) begin
        overrun_d = 1'b1;
        if (state == IDLE) begin
          rd_frame_d = last_good_frame_idx_i;
          avail_d    = AVAIL_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else begin
        avail_d = avail + AVAIL_W'(1);
      end
    end
  end

  // Accounting registers and word index
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_good_q <= '0;
      armed       <= 1'b0;
      avail       <= '0;
      rd_frame    <= '0;
      err_r       <= 1'b0;
      en_drop_r   <= 1'b0;
      word_idx    <= '0;
    end else begin
      last_good_q <= last_good_frame_idx_i;
      armed       <= armed_d;
      avail       <= avail_d;
      rd_frame    <= rd_frame_d;
      err_r       <= err_d;
      en_drop_r   <= en_drop_d;
      if (handshake)
        word_idx <= word_idx + WORD_IDX_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_d;
  end

  // FSM next state; after the last word, restart at once if frames remain
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (armed && (avail != '0) && enable_i) state_d = READ;
      READ: if (pk_done) state_d = HOLD;
      HOLD: begin
        if (word_ready_i) begin
          if (word_idx != LAST_WORD)
            state_d = READ;
          else if (armed_d && (avail_d != '0) && enable_i)
            state_d = READ;
          else
            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ram_read_addr_o = {rd_frame, word_idx, pk_bit_idx};
    ram_read_en_o   = pk_rd_en;
    word_data_o     = pk_word;
    word_valid_o    = (state == HOLD);
    word_last_o     = (state == HOLD) && (word_idx == LAST_WORD);
    word_err_o      = (state == HOLD) && (word_idx == LAST_WORD) && err_r;
    frame_idx_o     = rd_frame;
    overrun_o       = overrun_d;
  end

endmodule

// File: doc/i2s_frame_read_scheduler.md
Name: i2s_frame_read_scheduler

Overview:
- Sequences readout of completed I2S frames from the circular capture RAM filled by the I2S MSB receiver.
- Tracks the receiver's last-good-frame index and keeps a read pointer plus an available-frame count.
- Reads each 256-bit frame bit-serially from the RAM read port and packs it into eight 32-bit words on a valid/ready stream toward the USB packetiser.
- Detects writer overrun, marks the affected frame, and resynchronises to the newest good frame.

Parameters:
CIRC_BUF_BITS, 3, frame-index width; ring depth is 2**CIRC_BUF_BITS frames of 256 bits each.

Ports:
clk_i  in  1  the same x4 clock that drives the receiver
rst_i  in  1  reset, asynchronous, active-high
enable_i  in  1  permits frame readout
last_good_frame_idx_i  in  CIRC_BUF_BITS  receiver's newest complete frame
ram_read_addr_o  out  CIRC_BUF_BITS+8  {frame, bit index}
ram_read_en_o  out  1  read strobe; synchronous RAM, data valid 1 cycle later
ram_read_data_i  in  1  read bit
word_data_o  out  32  packed word
word_valid_o  out  1  word available
word_ready_i  in  1  consumer accepts
word_last_o  out  1  word 7 of the frame
word_err_o  out  1  with word_last_o: frame may be corrupted by overrun
frame_idx_o  out  CIRC_BUF_BITS  frame index of the current word
overrun_o  out  1  one-cycle pulse when an overrun is detected

Behaviour:
- Reset value of every output, and of every state register, is 0. The FSM resets to IDLE with armed=0 and avail=0.
- Frame event: last_good_q registers last_good_frame_idx_i every cycle. An event fires when the input differs from last_good_q.
- First event after reset or disarm, with enable_i=1: rd_frame=last_good_frame_idx_i, avail=1, armed=1. Earlier indices are never read.
- Armed event: avail+1. A frame completion (word 7 handshake) gives avail-1. Both in the same cycle: avail unchanged, rd_frame+1.
- avail width is CIRC_BUF_BITS+1.
- Overrun: an event that would make avail reach 2**CIRC_BUF_BITS.
  - overrun_o pulses in that cycle.
  - In IDLE: rd_frame=last_good_frame_idx_i, avail=1.
  - Mid-frame: set err_r. avail is held at 2**CIRC_BUF_BITS-1 while err_r is set. The frame completes, and its word 7 carries word_err_o=1. At completion, rd_frame=newest index and avail=1 instead of the normal update; err_r is cleared.
- FSM:
  - IDLE → READ when armed and avail!=0 and enable_i=1.
  - READ: for bit b=0..31 of word w, drive ram_read_addr_o={rd_frame, w*32+b} with ram_read_en_o=1. The data returned one cycle later shifts into a 32-bit register, MSB first: RAM bit w*32 lands in word bit 31.
  - READ → HOLD one cycle after the 32nd address, once the last bit is captured. word_valid_o rises 33 cycles after READ entry.
  - HOLD: word_valid_o=1. word_data_o, word_last_o, word_err_o and frame_idx_o stay stable until word_ready_i=1; no RAM reads occur.
  - On handshake: if w<7, w+1 and go to READ. If w=7, the frame completes; go to IDLE, or directly to READ if the start condition already holds.
- enable_i falling mid-frame: the current frame finishes normally. Then armed=0, avail=0, FSM goes to IDLE, and the next enable resyncs on a fresh event.
- Frame events while disarmed or disabled are ignored except for updating last_good_q.
- rd_frame and address arithmetic wrap modulo 2**CIRC_BUF_BITS and 256 respectively.
- rst_i mid-frame: immediate return to reset state. word_valid_o drops asynchronously.

Decomposition:
- Shared package: WORDS_PER_FRAME=8, BITS_PER_WORD=32, FRAME_BITS=256, and the state enum {IDLE, READ, HOLD}.
- One sub-module, i2s_bit_packer: a 32-bit serial-in shift register with a bit counter and a capture-done strobe, accounting for the 1-cycle RAM latency.
- Frame accounting (event detect, avail, rd_frame, overrun) and the FSM stay in the top module.

Test Plan:
1. Reset, then last_good steps 7→0, RAM frame 0 word 0 = 0xA5A5_0001 with word_ready_i=1 → first word_data_o=0xA5A5_0001 with frame_idx_o=0, word_valid_o at cycle 33 after READ entry; 8 words, the last with word_last_o=1 and word_err_o=0.
2. word_ready_i held low 100 cycles in HOLD → outputs stable, ram_read_en_o=0 throughout; one accepted word per handshake.
3. Four events before any readout → frames rd..rd+3 read in order, avail returns to 0, FSM in IDLE.
4. Consumer stalled while 8 events arrive, CIRC_BUF_BITS=3 → overrun_o pulses once. The frame in progress ends with word_err_o=1, the next frame_idx_o equals the newest last_good, avail=1.
5. Event coincident with word 7 handshake → avail unchanged, next frame starts the following cycle.
6. enable_i dropped at word 3 → frame finishes all 8 words. After re-enable, no readout until a new event; first read frame = the new index.
